// File: rtl/mos_rank_accum.sv
// Rank-sorted MOSFET I_D/g_m accumulator: result SEL_K+1 cycles after the last accept, held until out_ready.
// Define MOS_RANK_CLIP_EN to saturate device values and the sum; otherwise both wrap.
module mos_rank_accum #(
  parameter int NUM_DEV = 6,
  parameter int DW      = 3,
  parameter int VTH     = 1,
  parameter int VAL_W   = 6,
  parameter int SEL_K   = 3,
  parameter int OUT_W   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    w,
  input  logic [DW-1:0]    v_gs,
  input  logic [DW-1:0]    v_ds,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_n,
  output logic             busy
);

  localparam int CW    = 4*DW + 4;
  localparam int CNT_W = $clog2(NUM_DEV + 1);
  localparam int J_W   = $clog2(SEL_K + 1);
  localparam int WT_W  = J_W + 2;
  localparam int PW    = VAL_W + WT_W;

  typedef enum logic [1:0] {IDLE, COLLECT, ACCUM, DONE} state_t;

  state_t             state;
  logic               mode_id;
  logic               mode_top;
  logic [VAL_W-1:0]   ent [NUM_DEV];
  logic [CNT_W-1:0]   count;
  logic [J_W-1:0]     j;
  logic [PW-1:0]      prod;
  logic [OUT_W-1:0]   acc;

  // Device evaluation; vov is only meaningful outside cutoff, so unsigned math suffices.
  logic [CW-1:0]    w_x, vgs_x, vds_x, vov_x, num, raw;
  logic             cutoff, triode;
  logic [VAL_W-1:0] dev_val;

  always_comb begin
    w_x    = CW'(w);
    vgs_x  = CW'(v_gs);
    vds_x  = CW'(v_ds);
    cutoff = (vgs_x <= CW'(VTH));
    vov_x  = vgs_x - CW'(VTH);
    triode = (vov_x > vds_x);
    if (mode_id)
      num = triode ? w_x * (CW'(2) * vov_x * vds_x - vds_x * vds_x)
                   : w_x * vov_x * vov_x;
    else
      num = CW'(2) * w_x * (triode ? vds_x : vov_x);
    raw = cutoff ? '0 : num / CW'(3);
`ifdef MOS_RANK_CLIP_EN
    dev_val = (raw > CW'({VAL_W{1'b1}})) ? {VAL_W{1'b1}} : VAL_W'(raw);
`else
    dev_val = VAL_W'(raw);
`endif
  end

  // ge marks the valid prefix that stays ahead of the new value (ties keep arrival order).
  logic [NUM_DEV-1:0] ge;
  logic [VAL_W-1:0]   ent_ins [NUM_DEV];

  always_comb begin
    for (int i = 0; i < NUM_DEV; i++)
      ge[i] = (CNT_W'(i) < count) && (ent[i] >= dev_val);
    ent_ins[0] = ge[0] ? ent[0] : dev_val;
    for (int i = 1; i < NUM_DEV; i++) begin
      if (ge[i])
        ent_ins[i] = ent[i];
      else if (ge[i-1])
        ent_ins[i] = dev_val;
      else
        ent_ins[i] = ent[i-1];
    end
  end

  logic [VAL_W-1:0] term;
  logic [WT_W-1:0]  weight;
  logic [PW-1:0]    prod_next;
  logic [OUT_W-1:0] acc_next;

  always_comb begin
    term = '0;
    for (int k = 0; k < SEL_K; k++)
      if (j == J_W'(k))
        term = mode_top ? ent[k] : ent[NUM_DEV-SEL_K+k];
    weight    = mode_id ? WT_W'(j) + WT_W'(3) : WT_W'(1);
    prod_next = PW'(term) * PW'(weight);
  end

`ifdef MOS_RANK_CLIP_EN
  localparam int SW = ((OUT_W > PW) ? OUT_W : PW) + 1;
  logic [SW-1:0] acc_sum;

  always_comb begin
    acc_sum  = SW'(acc) + SW'(prod);
    acc_next = (acc_sum > SW'({OUT_W{1'b1}})) ? {OUT_W{1'b1}} : OUT_W'(acc_sum);
  end
`else
  always_comb begin
    acc_next = acc + OUT_W'(prod);
  end
`endif

  // ACCUM is a two-stage pipe: product registered at j, added at j+1; j==SEL_K drains the last term.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_n     <= '0;
      busy      <= 1'b0;
      mode_id   <= 1'b0;
      mode_top  <= 1'b0;
      count     <= '0;
      j         <= '0;
      prod      <= '0;
      acc       <= '0;
      for (int i = 0; i < NUM_DEV; i++) ent[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_id  <= mode[0];
            mode_top <= mode[1];
            for (int i = 0; i < NUM_DEV; i++) ent[i] <= '0;
            count    <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_DEV; i++) ent[i] <= ent_ins[i];
            count <= count + CNT_W'(1);
            if (count == CNT_W'(NUM_DEV - 1)) begin
              in_ready <= 1'b0;
              j        <= '0;
              acc      <= '0;
              state    <= ACCUM;
            end
          end
        end
        ACCUM: begin
          prod <= prod_next;
          if (j != '0) acc <= acc_next;
          j <= j + J_W'(1);
          if (j == J_W'(SEL_K)) begin
            out_n     <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mos_rank_accum.sv
// Scoreboard bench for mos_rank_accum: directed cases plus randomized jobs against a sort-and-sum model.
module tb_mos_rank_accum;

  localparam int NUM_DEV = 6;
  localparam int DW      = 3;
  localparam int VTH     = 1;
  localparam int VAL_W   = 6;
  localparam int SEL_K   = 3;
  localparam int OUT_W   = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    w, v_gs, v_ds;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_n;
  logic             busy;

  mos_rank_accum #(
    .NUM_DEV(NUM_DEV), .DW(DW), .VTH(VTH), .VAL_W(VAL_W), .SEL_K(SEL_K), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .w(w), .v_gs(v_gs), .v_ds(v_ds),
    .out_valid(out_valid), .out_ready(out_ready), .out_n(out_n), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];
  int last_acc_cyc = 0;
  bit lat_armed = 1'b0;
  int rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int red(input int v, input int bits);
`ifdef MOS_RANK_CLIP_EN
    return (v > (1 << bits) - 1) ? (1 << bits) - 1 : v;
`else
    return v % (1 << bits);
`endif
  endfunction

  function automatic int dev_model(input int wv, input int vg, input int vd, input bit id);
    int vov, r;
    vov = vg - VTH;
    if (vg <= VTH) r = 0;
    else if (vov > vd) r = id ? wv * (2*vov*vd - vd*vd) / 3 : 2*wv*vd / 3;
    else r = id ? wv * vov * vov / 3 : 2*wv*vov / 3;
    return red(r, VAL_W);
  endfunction

  function automatic int job_model(input logic [1:0] m, input int wa[NUM_DEV],
                                   input int vg[NUM_DEV], input int vd[NUM_DEV]);
    int vals[$];
    int total = 0;
    for (int i = 0; i < NUM_DEV; i++) vals.push_back(dev_model(wa[i], vg[i], vd[i], m[0]));
    vals.rsort();
    for (int k = 0; k < SEL_K; k++)
      total += vals[m[1] ? k : NUM_DEV - SEL_K + k] * (m[0] ? 3 + k : 1);
    return red(total, OUT_W);
  endfunction

  // ---------------- monitor ----------------
  logic [OUT_W-1:0] held;
  bit prev_pend = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_pend) begin
          held = out_n;
          if (lat_armed) begin
            check("latency", cyc - last_acc_cyc, SEL_K + 1);
            lat_armed = 1'b0;
          end
        end else begin
          check("hold_out_n", out_n, held);
        end
        if (out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out: got %0d expected no output", out_n);
          end else begin
            int e;
            e = exp_q.pop_front();
            if (out_n !== e[OUT_W-1:0]) begin
              failures++;
              $display("FAIL out_n: got %0d expected %0d", out_n, e);
            end
          end
        end
      end
      prev_pend = out_valid && !out_ready;
    end
  end

  // ---------------- out_ready driver ----------------
  int vcnt = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      vcnt = out_valid ? vcnt + 1 : 0;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (vcnt >= 6);
      endcase
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin tick(); n++; end
    check("idle_timeout", busy, 0);
  endtask

  task automatic begin_job(input logic [1:0] m);
    wait_idle();
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    mode  = 2'($urandom);
  endtask

  task automatic send_dev(input int wv, input int vg, input int vd, input int gmax);
    int n = 0;
    bit acc;
    repeat ($urandom_range(0, gmax)) begin
      in_valid = 1'b0;
      w = DW'($urandom);
      tick();
    end
    in_valid = 1'b1;
    w = DW'(wv); v_gs = DW'(vg); v_ds = DW'(vd);
    forever begin
      acc = in_ready;
      tick();
      if (acc) break;
      n++;
      if (n > 50) begin
        check("accept_timeout", in_ready, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_job(input logic [1:0] m, input int wa[NUM_DEV], input int vg[NUM_DEV],
                         input int vd[NUM_DEV], input int exp, input int gmax);
    begin_job(m);
    exp_q.push_back(exp);
    for (int i = 0; i < NUM_DEV; i++) send_dev(wa[i], vg[i], vd[i], gmax);
    last_acc_cyc = cyc;
    lat_armed = 1'b1;
  endtask

  int ws[NUM_DEV], vgu[NUM_DEV], vgd[NUM_DEV], v7[NUM_DEV], rw[NUM_DEV], rg[NUM_DEV], rd[NUM_DEV];

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'b00; in_valid = 1'b0;
    w = '0; v_gs = '0; v_ds = '0;
    ws  = '{3, 3, 3, 3, 3, 3};
    vgu = '{2, 3, 4, 5, 6, 7};
    vgd = '{7, 6, 5, 4, 3, 2};
    v7  = '{7, 7, 7, 7, 7, 7};
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_n", out_n, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    // Directed ramp, both orders.
    run_job(2'b10, ws, vgu, v7, 30, 0);
    run_job(2'b00, ws, vgu, v7, 12, 0);
    run_job(2'b11, ws, vgu, v7, 288, 0);
    run_job(2'b01, ws, vgu, v7, 48, 0);
    run_job(2'b11, ws, vgd, v7, 288, 2);
    run_job(2'b01, ws, vgd, v7, 48, 2);

    // Large devices: per-device saturation vs wrap.
`ifdef MOS_RANK_CLIP_EN
    run_job(2'b11, v7, v7, v7, 756, 1);
`else
    run_job(2'b11, v7, v7, v7, 240, 1);
`endif
    run_job(2'b10, v7, v7, v7, 84, 1);

    // Cutoff in every mode.
    for (int m = 0; m < 4; m++) begin
      for (int i = 0; i < NUM_DEV; i++) begin
        rw[i] = $urandom_range(0, 7); rg[i] = $urandom_range(0, 1); rd[i] = $urandom_range(0, 7);
      end
      run_job(2'(m), rw, rg, rd, 0, 1);
    end

    // Reset after three accepts abandons the job and clears out_n.
    begin_job(2'b11);
    for (int i = 0; i < 3; i++) send_dev(3, vgu[i], 7, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_n", out_n, 0);
    tick();
    run_job(2'b11, ws, vgu, v7, 288, 0);

    // Backpressure with start pulses while DONE.
    wait_idle();
    rdy_mode = 2;
    run_job(2'b01, ws, vgd, v7, 48, 0);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      check("done_reached", out_valid, 1);
    end
    start = 1'b1; mode = 2'b11;
    repeat (3) tick();
    start = 1'b0;
    wait_idle();
    tick();
    check("start_in_done_ignored", busy, 0);
    rdy_mode = 1;

    // Randomized jobs.
    for (int t = 0; t < 40; t++) begin
      logic [1:0] m;
      m = 2'($urandom);
      for (int i = 0; i < NUM_DEV; i++) begin
        rw[i] = $urandom_range(0, 7); rg[i] = $urandom_range(0, 7); rd[i] = $urandom_range(0, 7);
      end
      run_job(m, rw, rg, rd, job_model(m, rw, rg, rd), 2);
    end

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
      check("drain", exp_q.size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
